lu_selftest_seq: RTL and testbench

//  Self-test sequencer sitting on the input side of the 2-input logic unit (ops selected by
//  2-bit sel: 00 NOR, 01 OR, 10 XOR, 11 XNOR). On start it drives all 16 {sel,a,b} vectors

---
 rtl/lu_selftest_seq.sv | 141 ++++++++++++++
 tb/tb_lu_selftest_seq.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/lu_selftest_seq.sv
// lu_selftest_seq: self-test sequencer for a 2-input logic unit
// (sel 00 NOR, 01 OR, 10 XOR, 11 XNOR). On start it drives all 16 {sel,a,b}
// vectors in order, samples y_i, and compares it against an internal golden
// model. It reports done/pass, a saturating error count and the index of the
// first failing vector.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   start                 run request, honoured only in IDLE or DONE
//   y_i                   result from the logic unit under test
//   a_o, b_o, sel_o       stimulus to the logic unit (registered decode of idx)
//   busy, done, pass      run status (registered)
//   err_count             saturating mismatch count
//   fail_valid, fail_idx  first-mismatch flag and its {sel,a,b} index
module lu_selftest_seq #(
  parameter int unsigned SETTLE = 1,
  parameter int unsigned ERR_W  = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             y_i,
  output logic             a_o,
  output logic             b_o,
  output logic [1:0]       sel_o,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic             fail_valid,
  output logic [3:0]       fail_idx
);

  localparam int unsigned      CNT_W      = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(SETTLE - 1);
  localparam logic [ERR_W-1:0] ERR_MAX    = '1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_CHECK,
    S_DONE
  } state_e;

  state_e           state_q;
  logic [3:0]       idx_q;
  logic [CNT_W-1:0] cnt_q;
  logic [3:0]       vec_q;
  logic             busy_q;
  logic             done_q;
  logic             pass_q;
  logic [ERR_W-1:0] err_q;
  logic             fail_valid_q;
  logic [3:0]       fail_idx_q;

  logic             exp_c;
  logic             start_ok_c;

  // Golden model of the logic unit for the current vector
  always_comb begin
    exp_c = 1'b0;
    case (idx_q[3:2])
      2'b00:   exp_c = ~(idx_q[1] | idx_q[0]);
      2'b01:   exp_c = idx_q[1] | idx_q[0];
      2'b10:   exp_c = idx_q[1] ^ idx_q[0];
      default: exp_c = ~(idx_q[1] ^ idx_q[0]);
    endcase
  end

  assign start_ok_c = start && ((state_q == S_IDLE) || (state_q == S_DONE));

  // Sequencer FSM; status and vector outputs are a registered decode of the
  // state/index, so they trail the state register by one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      idx_q        <= 4'd0;
      cnt_q        <= '0;
      vec_q        <= 4'd0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      err_q        <= '0;
      fail_valid_q <= 1'b0;
      fail_idx_q   <= 4'd0;
    end else begin
      vec_q  <= idx_q;
      busy_q <= (state_q == S_SETTLE) || (state_q == S_CHECK);
      // A start accepted in DONE drops done/pass on the same edge
      done_q <= (state_q == S_DONE) && !start;
      pass_q <= (state_q == S_DONE) && !start && (err_q == '0);

      case (state_q)
        S_IDLE, S_DONE: begin
          if (start_ok_c) begin
            idx_q        <= 4'd0;
            cnt_q        <= CNT_RELOAD;
            err_q        <= '0;
            fail_valid_q <= 1'b0;
            fail_idx_q   <= 4'd0;
            state_q      <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (cnt_q == '0) begin
            state_q <= S_CHECK;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        S_CHECK: begin
          if (y_i != exp_c) begin
            if (err_q != ERR_MAX) begin
              err_q <= err_q + ERR_W'(1);
            end
            if (!fail_valid_q) begin
              fail_valid_q <= 1'b1;
              fail_idx_q   <= idx_q;
            end
          end
          if (idx_q == 4'hF) begin
            state_q <= S_DONE;
          end else begin
            idx_q   <= idx_q + 4'd1;
            cnt_q   <= CNT_RELOAD;
            state_q <= S_SETTLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign {sel_o, a_o, b_o} = vec_q;
  assign busy              = busy_q;
  assign done              = done_q;
  assign pass              = pass_q;
  assign err_count         = err_q;
  assign fail_valid        = fail_valid_q;
  assign fail_idx          = fail_idx_q;

endmodule

// File: tb/tb_lu_selftest_seq.sv
// Directed bench for lu_selftest_seq: a default instance (SETTLE=1, ERR_W=5)
// and a narrow-count instance (ERR_W=3) driven by an inverted logic unit.
module tb_lu_selftest_seq;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       start3;
  logic [1:0] mode;  // 0 golden, 1 tied 0, 2 tied 1, 3 inverted

  logic       a, b, y;
  logic [1:0] sel;
  logic       busy, done, pass, fail_valid;
  logic [4:0] err_count;
  logic [3:0] fail_idx;

  logic       a3, b3, y3;
  logic [1:0] sel3;
  logic       busy3, done3, pass3, fail_valid3;
  logic [2:0] err_count3;
  logic [3:0] fail_idx3;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  function automatic logic lu(input logic [1:0] s, input logic aa, input logic bb);
    case (s)
      2'b00:   return ~(aa | bb);
      2'b01:   return aa | bb;
      2'b10:   return aa ^ bb;
      default: return ~(aa ^ bb);
    endcase
  endfunction

  always_comb begin
    case (mode)
      2'd0:    y = lu(sel, a, b);
      2'd1:    y = 1'b0;
      2'd2:    y = 1'b1;
      default: y = ~lu(sel, a, b);
    endcase
  end

  assign y3 = ~lu(sel3, a3, b3);

  lu_selftest_seq #(.SETTLE(1), .ERR_W(5)) dut (
    .clk(clk), .reset(reset), .start(start), .y_i(y),
    .a_o(a), .b_o(b), .sel_o(sel),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .fail_valid(fail_valid), .fail_idx(fail_idx)
  );

  lu_selftest_seq #(.SETTLE(1), .ERR_W(3)) dut3 (
    .clk(clk), .reset(reset), .start(start3), .y_i(y3),
    .a_o(a3), .b_o(b3), .sel_o(sel3),
    .busy(busy3), .done(done3), .pass(pass3), .err_count(err_count3),
    .fail_valid(fail_valid3), .fail_idx(fail_idx3)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_a"},    32'(a), 32'd0);
    check({tag, "_b"},    32'(b), 32'd0);
    check({tag, "_sel"},  32'(sel), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_pass"}, 32'(pass), 32'd0);
    check({tag, "_err"},  32'(err_count), 32'd0);
    check({tag, "_fv"},   32'(fail_valid), 32'd0);
    check({tag, "_fi"},   32'(fail_idx), 32'd0);
  endtask

  // Pulse start, optionally pulse it again mid-run, and follow the sweep to
  // done. cyc counts edges from the start-sampling edge to done visible;
  // order_ok means the unit saw vectors 0..15 exactly once each, in order.
  task automatic run(input string tag, input int mid_start,
                     output int cyc, output int bcyc, output logic order_ok);
    logic [3:0] v;
    logic [3:0] last;
    int nv;
    cyc = 0; bcyc = 0; nv = 0; order_ok = 1'b1; last = 4'd0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    check({tag, "_clr_done"}, 32'(done), 32'd0);
    check({tag, "_clr_err"},  32'(err_count), 32'd0);
    check({tag, "_clr_fv"},   32'(fail_valid), 32'd0);
    while (!done && cyc < 200) begin
      @(posedge clk);
      cyc++;
      #1 start = (cyc == mid_start);
      if (busy) begin
        bcyc++;
        v = {sel, a, b};
        if (nv == 0 || v != last) begin
          if (v != 4'(nv)) order_ok = 1'b0;
          nv++;
          last = v;
        end
      end
    end
    start = 1'b0;
    if (nv != 16) order_ok = 1'b0;
    check({tag, "_done"}, 32'(done), 32'd1);
  endtask

  initial begin
    int cyc, bcyc, waited;
    logic ok;

    reset = 1'b1; start = 1'b0; start3 = 1'b0; mode = 2'd0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("rst");
    check("rst_err3", 32'(err_count3), 32'd0);
    reset = 1'b0;

    // Golden unit: full pass
    mode = 2'd0;
    run("gold", 0, cyc, bcyc, ok);
    check("gold_latency", 32'(cyc), 32'd33);
    check("gold_busy_cycles", 32'(bcyc), 32'd32);
    check("gold_order", 32'(ok), 32'd1);
    check("gold_pass", 32'(pass), 32'd1);
    check("gold_err", 32'(err_count), 32'd0);
    check("gold_fv", 32'(fail_valid), 32'd0);
    check("gold_vec_hold", 32'({sel, a, b}), 32'hF);
    repeat (3) @(posedge clk);
    #1;
    check("gold_done_stays", 32'(done), 32'd1);
    check("gold_pass_stays", 32'(pass), 32'd1);

    // y stuck at 0
    mode = 2'd1;
    run("y0", 0, cyc, bcyc, ok);
    check("y0_err", 32'(err_count), 32'd8);
    check("y0_fv", 32'(fail_valid), 32'd1);
    check("y0_fi", 32'(fail_idx), 32'h0);
    check("y0_pass", 32'(pass), 32'd0);

    // y stuck at 1
    mode = 2'd2;
    run("y1", 0, cyc, bcyc, ok);
    check("y1_err", 32'(err_count), 32'd8);
    check("y1_fv", 32'(fail_valid), 32'd1);
    check("y1_fi", 32'(fail_idx), 32'h1);
    check("y1_pass", 32'(pass), 32'd0);

    // Restart from DONE with errors pending, plus a start pulse while busy
    mode = 2'd0;
    run("busy_start", 10, cyc, bcyc, ok);
    check("busy_start_latency", 32'(cyc), 32'd33);
    check("busy_start_busy_cycles", 32'(bcyc), 32'd32);
    check("busy_start_order", 32'(ok), 32'd1);
    check("busy_start_pass", 32'(pass), 32'd1);
    check("busy_start_err", 32'(err_count), 32'd0);

    // Reset mid-run at idx 7, with start asserted alongside reset
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    waited = 0;
    while (dut.idx_q != 4'd7 && waited < 100) begin
      @(posedge clk);
      waited++;
      #1;
    end
    check("midrun_reached_idx7", 32'(dut.idx_q), 32'd7);
    reset = 1'b1; start = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0; start = 1'b0;
    check_all_zero("midrst");
    @(posedge clk);
    #1;
    check("midrst_idle_busy", 32'(busy), 32'd0);
    check("midrst_idle_vec", 32'({sel, a, b}), 32'h0);
    run("after_rst", 0, cyc, bcyc, ok);
    check("after_rst_latency", 32'(cyc), 32'd33);
    check("after_rst_order", 32'(ok), 32'd1);
    check("after_rst_pass", 32'(pass), 32'd1);

    // Narrow counter saturates with an inverted unit
    @(negedge clk);
    start3 = 1'b1;
    @(negedge clk);
    start3 = 1'b0;
    waited = 0;
    while (!done3 && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    check("sat_done", 32'(done3), 32'd1);
    check("sat_err", 32'(err_count3), 32'd7);
    check("sat_fv", 32'(fail_valid3), 32'd1);
    check("sat_fi", 32'(fail_idx3), 32'h0);
    check("sat_pass", 32'(pass3), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
